// File: rtl/reset_sequencer_if.sv
// rtl/reset_sequencer_if.sv - memory/CPU reset handshake and status bundle for reset_sequencer
interface reset_sequencer_if;
    logic mem_ready;
    logic soft_rst;
    logic mem_nreset;
    logic cpu_nreset;
    logic running;
    logic mem_timeout;
    logic led;

    // The sequencer owns the reset/status outputs and samples the handshake inputs.
    modport master (
        input  mem_ready,
        input  soft_rst,
        output mem_nreset,
        output cpu_nreset,
        output running,
        output mem_timeout,
        output led
    );

    // Reset consumers: memory subsystem, CPU, soft-reset source, LED.
    modport slave (
        output mem_ready,
        output soft_rst,
        input  mem_nreset,
        input  cpu_nreset,
        input  running,
        input  mem_timeout,
        input  led
    );
endinterface

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - board reset filter and memory-then-CPU release sequencer
module reset_sequencer #(
    parameter int SYNC_STAGES     = 2,
    parameter int HOLD_CYCLES     = 16,
    parameter int MEM_TIMEOUT     = 1024,
    parameter int CPU_DELAY       = 8,
    // LED toggles every 2**LED_TOGGLE_LOG2 cycles when running after a timeout.
    parameter int LED_TOGGLE_LOG2 = 20
) (
    input  logic              clk,
    input  logic              nreset,
    reset_sequencer_if.master bus
);

    localparam int MAX_HM = (HOLD_CYCLES > MEM_TIMEOUT) ? HOLD_CYCLES : MEM_TIMEOUT;
    localparam int MAX_ALL = (MAX_HM > CPU_DELAY) ? MAX_HM : CPU_DELAY;
    localparam int CW = $clog2(MAX_ALL + 1);

    typedef enum logic [1:0] {
        ST_HOLD,
        ST_MEM_WAIT,
        ST_CPU_DLY,
        ST_RUN
    } state_t;

    logic [SYNC_STAGES-1:0]     sync_q;
    logic                       s_rst;
    state_t                     state_q, state_d;
    logic [CW-1:0]              cnt_q, cnt_d, cnt_inc;
    logic [LED_TOGGLE_LOG2-1:0] led_cnt_q, led_cnt_d;
    logic                       mem_nreset_q, mem_nreset_d;
    logic                       cpu_nreset_q, cpu_nreset_d;
    logic                       running_q, running_d;
    logic                       timeout_q, timeout_d;
    logic                       led_q, led_d;

    assign s_rst = sync_q[SYNC_STAGES-1];

    // Deassertion synchronizer: shifts in 1 once nreset is released, cleared asynchronously.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    // Sequencer state, shared counter and all registered outputs.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q      <= ST_HOLD;
            cnt_q        <= '0;
            led_cnt_q    <= '0;
            mem_nreset_q <= 1'b0;
            cpu_nreset_q <= 1'b0;
            running_q    <= 1'b0;
            timeout_q    <= 1'b0;
            led_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            led_cnt_q    <= led_cnt_d;
            mem_nreset_q <= mem_nreset_d;
            cpu_nreset_q <= cpu_nreset_d;
            running_q    <= running_d;
            timeout_q    <= timeout_d;
            led_q        <= led_d;
        end
    end

    // Next-state logic; outputs are derived from the next state so they change on the transition edge.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        cnt_inc   = cnt_q + CW'(1);

        case (state_q)
            ST_HOLD: begin
                if (s_rst) begin
                    if (cnt_inc == CW'(HOLD_CYCLES)) begin
                        state_d = ST_MEM_WAIT;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            ST_MEM_WAIT: begin
                // Ready wins over a timeout that would expire on the same edge.
                if (bus.mem_ready) begin
                    state_d = ST_CPU_DLY;
                    cnt_d   = '0;
                end else if (cnt_inc == CW'(MEM_TIMEOUT)) begin
                    timeout_d = 1'b1;
                    state_d   = ST_CPU_DLY;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_CPU_DLY: begin
                if (cnt_inc == CW'(CPU_DELAY)) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_RUN: begin
                if (bus.soft_rst) begin
                    state_d = ST_CPU_DLY;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_HOLD;
                cnt_d   = '0;
            end
        endcase

        // Memory stays released once out of HOLD; only nreset can take it back.
        mem_nreset_d = (state_d != ST_HOLD);
        cpu_nreset_d = (state_d == ST_RUN);
        running_d    = (state_d == ST_RUN);

        led_cnt_d = (state_q == ST_RUN) ? led_cnt_q + LED_TOGGLE_LOG2'(1) : '0;
        if (state_d != ST_RUN) begin
            led_d = 1'b0;
        end else if (!timeout_d) begin
            led_d = 1'b1;
        end else begin
            led_d = led_q ^ ((state_q == ST_RUN) && (&led_cnt_q));
        end
    end

    assign bus.mem_nreset  = mem_nreset_q;
    assign bus.cpu_nreset  = cpu_nreset_q;
    assign bus.running     = running_q;
    assign bus.mem_timeout = timeout_q;
    assign bus.led         = led_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - directed self-checking bench for reset_sequencer
module tb_reset_sequencer;

    localparam int LED_LOG2 = 4;

    logic clk = 1'b0;
    logic nreset = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;
    int   edge_n = 0;

    reset_sequencer_if bus_if();

    reset_sequencer #(
        .SYNC_STAGES    (2),
        .HOLD_CYCLES    (16),
        .MEM_TIMEOUT    (1024),
        .CPU_DELAY      (8),
        .LED_TOGGLE_LOG2(LED_LOG2)
    ) dut (
        .clk   (clk),
        .nreset(nreset),
        .bus   (bus_if.master)
    );

    always #5 clk = ~clk;

    // {mem_nreset, cpu_nreset, running, mem_timeout, led}
    function automatic logic [4:0] outs();
        return {bus_if.mem_nreset, bus_if.cpu_nreset, bus_if.running, bus_if.mem_timeout, bus_if.led};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        edge_n++;
    endtask

    // Hold nreset low for 3 edges, then release mid-cycle so the next posedge is E1.
    task automatic restart();
        nreset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        nreset = 1'b1;
        edge_n = 0;
    endtask

    task automatic test_reset();
        logic [4:0] got;
        bus_if.mem_ready = 1'b1;
        bus_if.soft_rst  = 1'b0;
        nreset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            got = outs();
            vectors++;
            if (got !== 5'b00000) begin
                $display("FAIL reset_state cycle %0d: got %b want %b", i, got, 5'b00000);
                miscompares++;
            end
        end
    endtask

    task automatic test_power_on();
        logic [4:0] got, exp;
        bus_if.mem_ready = 1'b1;
        restart();
        for (int e = 1; e <= 30; e++) begin
            tick();
            got = outs();
            exp = {e >= 18, e >= 27, e >= 27, 1'b0, e >= 27};
            vectors++;
            if (got !== exp) begin
                $display("FAIL power_on E%0d: got %b want %b", e, got, exp);
                miscompares++;
            end
        end
    endtask

    task automatic test_soft_reset();
        logic [4:0] got, exp;
        // Starts in RUN with no timeout.
        bus_if.soft_rst = 1'b1;
        tick();
        bus_if.soft_rst = 1'b0;
        got = outs();
        vectors++;
        if (got !== 5'b10000) begin
            $display("FAIL soft_rst_edge: got %b want %b", got, 5'b10000);
            miscompares++;
        end
        for (int k = 1; k <= 10; k++) begin
            // A pulse during CPU_DLY must not restart the delay.
            bus_if.soft_rst = (k == 3);
            tick();
            got = outs();
            exp = {1'b1, k >= 8, k >= 8, 1'b0, k >= 8};
            vectors++;
            if (got !== exp) begin
                $display("FAIL soft_rst_release k=%0d: got %b want %b", k, got, exp);
                miscompares++;
            end
        end
        bus_if.soft_rst = 1'b0;
    endtask

    task automatic test_delayed_memory();
        logic [4:0] got, exp;
        bus_if.mem_ready = 1'b0;
        restart();
        for (int e = 1; e <= 130; e++) begin
            tick();
            if (e == 118) bus_if.mem_ready = 1'b1;
            got = outs();
            exp = {e >= 18, e >= 127, e >= 127, 1'b0, e >= 127};
            vectors++;
            if (got !== exp) begin
                $display("FAIL delayed_mem E%0d: got %b want %b", e, got, exp);
                miscompares++;
            end
        end
    endtask

    task automatic test_timeout();
        logic [4:0] got, exp;
        logic       led_exp;
        bus_if.mem_ready = 1'b0;
        restart();
        for (int e = 1; e <= 1050 + 80; e++) begin
            tick();
            got = outs();
            led_exp = (e >= 1050) ? (((e - 1050) / (1 << LED_LOG2)) % 2 == 1) : 1'b0;
            exp = {e >= 18, e >= 1050, e >= 1050, e >= 1042, led_exp};
            vectors++;
            if (got !== exp) begin
                $display("FAIL timeout E%0d: got %b want %b", e, got, exp);
                miscompares++;
            end
        end
    endtask

    task automatic test_mid_sequence_reset();
        logic [4:0] got, exp;
        vectors++;
        if (bus_if.mem_timeout !== 1'b1) begin
            $display("FAIL pre_glitch_timeout: got %b want 1", bus_if.mem_timeout);
            miscompares++;
        end
        // 2 ns glitch in RUN after a timeout; outputs must clear with no clock edge.
        #2 nreset = 1'b0;
        #1 got = outs();
        vectors++;
        if (got !== 5'b00000) begin
            $display("FAIL async_clear_run: got %b want %b", got, 5'b00000);
            miscompares++;
        end
        #1 nreset = 1'b1;
        edge_n = 0;
        bus_if.mem_ready = 1'b0;
        for (int e = 1; e <= 20; e++) begin
            tick();
            got = outs();
            exp = {e >= 18, 4'b0000};
            vectors++;
            if (got !== exp) begin
                $display("FAIL restart_to_memwait E%0d: got %b want %b", e, got, exp);
                miscompares++;
            end
        end
        // Second glitch while in MEM_WAIT.
        #2 nreset = 1'b0;
        #1 got = outs();
        vectors++;
        if (got !== 5'b00000) begin
            $display("FAIL async_clear_memwait: got %b want %b", got, 5'b00000);
            miscompares++;
        end
        #1 nreset = 1'b1;
        edge_n = 0;
        bus_if.mem_ready = 1'b1;
        for (int e = 1; e <= 28; e++) begin
            tick();
            got = outs();
            exp = {e >= 18, e >= 27, e >= 27, 1'b0, e >= 27};
            vectors++;
            if (got !== exp) begin
                $display("FAIL glitch_repeat E%0d: got %b want %b", e, got, exp);
                miscompares++;
            end
        end
    endtask

    task automatic test_reset_held();
        logic [4:0] got;
        nreset = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            bus_if.mem_ready = 1'($urandom);
            bus_if.soft_rst  = 1'($urandom);
            tick();
            got = outs();
            vectors++;
            if (got !== 5'b00000) begin
                $display("FAIL reset_held cycle %0d: got %b want %b", i, got, 5'b00000);
                miscompares++;
            end
        end
        bus_if.soft_rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_if.mem_ready = 1'b0;
        bus_if.soft_rst  = 1'b0;
        test_reset();
        test_power_on();
        test_soft_reset();
        test_delayed_memory();
        test_timeout();
        test_mid_sequence_reset();
        test_reset_held();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Front-end for the board reset that a bench or the board button drives into FPGC6.
- Filters and synchronizes the asynchronous active-low `nreset`.
- Releases the memory subsystem first, waits for its ready handshake, then releases the CPU after a programmable delay.
- Supports a CPU-only soft reset and drives a status LED.
- Sits directly under the FPGC6 top level, between the `nreset` pin and all internal reset consumers.

Parameters:
- SYNC_STAGES, 2: synchronizer depth for `nreset` deassertion; minimum 2.
- HOLD_CYCLES, 16: synchronized-high cycles required before memory release; minimum 1.
- MEM_TIMEOUT, 1024: maximum cycles spent waiting for `mem_ready`.
- CPU_DELAY, 8: cycles between the memory-ready event and CPU release; minimum 1.

Ports:
- clk  in  1  system clock; only clock.
- nreset  in  1  board reset, asynchronous, active-low.
- mem_ready  in  1  memory init done, synchronous to clk; level-sensitive.
- soft_rst  in  1  CPU-only reset request, 1-cycle pulse, synchronous.
- mem_nreset  out  1  active-low reset to MemoryUnit/L1Dcache.
- cpu_nreset  out  1  active-low reset to CPU.
- running  out  1  high in RUN state.
- mem_timeout  out  1  sticky flag: memory release timed out.
- led  out  1  status LED.

Behaviour:
- Clock and reset: one clock, `clk`; reset `nreset` is asynchronous, active-low.

Reset assertion:
- `nreset` low immediately and asynchronously clears all flops: synchronizer chain, state, counters, `mem_timeout`.
- While `nreset` is low: `mem_nreset`=0, `cpu_nreset`=0, `running`=0, `mem_timeout`=0, `led`=0.
- No combinational path from any input to any output; all outputs are registered.

Deassertion:
- A SYNC_STAGES-deep chain, reset by `nreset`, shifts in 1. Its last stage is `s_rst`.
- Let E1 be the first rising edge with `nreset` high. `s_rst` becomes 1 at E(SYNC_STAGES).

FSM states: HOLD, MEM_WAIT, CPU_DLY, RUN. Reset state is HOLD.
- HOLD:
  - Counter increments on each edge where `s_rst`=1.
  - On the edge where count reaches HOLD_CYCLES: go to MEM_WAIT, set `mem_nreset`=1, clear counter.
  - Defaults: `mem_nreset` rises at E(SYNC_STAGES+HOLD_CYCLES) = E18.
- MEM_WAIT:
  - `mem_ready` is sampled on each edge, starting with the first edge after entry.
  - If `mem_ready`=1: go to CPU_DLY and clear counter.
  - Otherwise the counter increments. When it reaches MEM_TIMEOUT: set `mem_timeout`=1 and go to CPU_DLY anyway.
- CPU_DLY:
  - Counter increments each edge.
  - On the edge where it reaches CPU_DELAY: set `cpu_nreset`=1, `running`=1, go to RUN.
- RUN:
  - `mem_ready` changes are ignored.
  - `soft_rst`=1 on an edge: `cpu_nreset`=0 and `running`=0 on that edge, go to CPU_DLY, clear counter. `mem_nreset` stays 1.
- `soft_rst` is ignored in HOLD, MEM_WAIT and CPU_DLY; it neither extends nor restarts the delay.

Width and boundary rules:
- Counter width is clog2 of max(HOLD_CYCLES, MEM_TIMEOUT, CPU_DELAY)+1 and must not wrap.
- `mem_ready` already high on MEM_WAIT entry: leave MEM_WAIT on the first edge after entry.
- `mem_ready` arriving on the same edge as the timeout: treat as ready; `mem_timeout` stays 0.
- `nreset` glitch low at any point, including mid-sequence or in RUN: full restart from HOLD; `mem_timeout` is cleared.

LED:
- `led` = 1 only in RUN with `mem_timeout`=0.
- RUN with `mem_timeout`=1: `led` toggles every 2^20 cycles.
- All other states: `led`=0.

Test Plan:
- Power-on, defaults:
  - Stimulus: `nreset` low for 3 cycles then high; `mem_ready` tied 1.
  - Required: `mem_nreset` rises at E18. `cpu_nreset` and `running` rise at E27 (E19 + 8). `mem_timeout`=0 and `led`=1 from E27.
- Delayed memory:
  - Stimulus: `mem_ready` rises 100 cycles after `mem_nreset`.
  - Required: `cpu_nreset` rises exactly 8 edges after the first edge sampling `mem_ready`=1. `mem_timeout`=0.
- Timeout:
  - Stimulus: `mem_ready` held 0.
  - Required: `mem_timeout`=1 at 1024 edges after MEM_WAIT entry. `cpu_nreset` rises 8 edges later. `led` toggles with period 2^21 cycles.
- Soft reset:
  - Stimulus: in RUN, 1-cycle `soft_rst`.
  - Required: `cpu_nreset` low on that edge and high again 8 edges later; `mem_nreset` stays 1 throughout.
  - Also: a `soft_rst` pulse issued during CPU_DLY has no effect on release timing.
- Mid-sequence reset:
  - Stimulus: `nreset` pulsed low for 2 ns during MEM_WAIT, after a prior timeout.
  - Required: all outputs go 0 asynchronously without waiting for a clock edge. `mem_timeout` is cleared. The full power-on timing repeats from the new E1.
- Reset held:
  - Stimulus: `nreset` low for 1000 cycles with `clk` toggling and `mem_ready`/`soft_rst` toggling.
  - Required: every output stays 0 throughout.
